// File: rtl/spi_omega_rx.sv
// spi_omega_rx -- SPI slave receiver that accepts a 64-bit omega word.
//
// The SPI pins are asynchronous to CLK67MHZ. Each pin passes through a
// SYNC_STAGES-deep synchronizer. The design then detects SCK and SSEL edges
// on the system clock. A frame is the span between an SSEL falling edge and
// the next SSEL rising edge, with data sent MSB first on SCK rising edges.
// A frame is accepted only if it holds exactly the frame length in bits.
// An accepted frame updates omegaOut. A rejected frame pulses frameErr and
// bumps a saturating error counter.
//
// Optional feature: define SPI_OMEGA_RX_CRC8_EN to use a 72-bit frame.
// The frame is 64 data bits followed by a CRC-8 (poly 0x07, init 0x00)
// that covers the data bits.
//
// Ports:
//   CLK67MHZ   in   system clock, rising edge
//   resetPort  in   synchronous active-low reset
//   sckPort    in   SPI clock (async)
//   mosiPort   in   SPI data, MSB first (async)
//   sselPort   in   SPI slave select, active-low (async)
//   omegaOut   out  [63:0] last accepted omega word
//   omegaValid out  one-cycle pulse when omegaOut updates
//   frameErr   out  one-cycle pulse when a frame is rejected
//   errCount   out  [ERR_CNT_W-1:0] saturating rejected-frame count
//   busy       out  high while shifting a frame
module spi_omega_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                 CLK67MHZ,
  input  logic                 resetPort,
  input  logic                 sckPort,
  input  logic                 mosiPort,
  input  logic                 sselPort,
  output logic [63:0]          omegaOut,
  output logic                 omegaValid,
  output logic                 frameErr,
  output logic [ERR_CNT_W-1:0] errCount,
  output logic                 busy
);

`ifdef SPI_OMEGA_RX_CRC8_EN
  localparam int unsigned FRAME_LEN = 72;
`else
  localparam int unsigned FRAME_LEN = 64;
`endif
  localparam logic [6:0] FRAME_LEN_C = 7'(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, ssel_sync;
  logic                   sck_prev, ssel_prev;
  logic                   sck_s, mosi_s, ssel_s;
  logic                   sck_rise, ssel_rise, ssel_fall;
  state_t                 state, state_next;
  logic                   enter_shift, sck_take;
  logic [FRAME_LEN-1:0]   sreg;
  logic [6:0]             bit_cnt;
  logic                   ovf;
  logic [63:0]            data;
  logic                   crc_ok, accept;

  // Synchronizers and edge-history registers
  always_ff @(posedge CLK67MHZ) begin
    if (!resetPort) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      ssel_sync <= '0;
      sck_prev  <= 1'b0;
      ssel_prev <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sckPort};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosiPort};
      ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], sselPort};
      sck_prev  <= sck_s;
      ssel_prev <= ssel_s;
    end
  end

  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ssel_s    = ssel_sync[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_prev;
  assign ssel_rise = ssel_s & ~ssel_prev;
  assign ssel_fall = ~ssel_s & ssel_prev;

  always_ff @(posedge CLK67MHZ) begin
    if (!resetPort) state <= IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ssel_fall) state_next = SHIFT;
      SHIFT:   if (ssel_rise) state_next = CHECK;
      CHECK:   state_next = ssel_fall ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy        = (state == SHIFT);
  assign enter_shift = (state_next == SHIFT) && (state != SHIFT);
  // An SCK edge that coincides with the closing SSEL edge is not part of the frame
  assign sck_take    = (state == SHIFT) && sck_rise && !ssel_rise;

  // Shift register, bit counter and sticky overflow; counter stops at FRAME_LEN
  always_ff @(posedge CLK67MHZ) begin
    if (!resetPort || enter_shift) begin
      sreg    <= '0;
      bit_cnt <= '0;
      ovf     <= 1'b0;
    end else if (sck_take) begin
      if (bit_cnt == FRAME_LEN_C) begin
        ovf <= 1'b1;
      end else begin
        sreg    <= {sreg[FRAME_LEN-2:0], mosi_s};
        bit_cnt <= bit_cnt + 7'd1;
      end
    end
  end

`ifdef SPI_OMEGA_RX_CRC8_EN
  // Serial CRC-8 over the first 64 received bits; the trailing 8 bits are the sent CRC
  logic [7:0] crc;

  always_ff @(posedge CLK67MHZ) begin
    if (!resetPort || enter_shift) begin
      crc <= '0;
    end else if (sck_take && bit_cnt < 7'd64) begin
      crc <= {crc[6:0], 1'b0} ^ ({8{crc[7] ^ mosi_s}} & 8'h07);
    end
  end

  assign data   = sreg[71:8];
  assign crc_ok = (crc == sreg[7:0]);
`else
  assign data   = sreg;
  assign crc_ok = 1'b1;
`endif

  assign accept = (bit_cnt == FRAME_LEN_C) && !ovf && crc_ok;

  always_ff @(posedge CLK67MHZ) begin
    if (!resetPort) begin
      omegaOut   <= '0;
      omegaValid <= 1'b0;
      frameErr   <= 1'b0;
      errCount   <= '0;
    end else begin
      omegaValid <= 1'b0;
      frameErr   <= 1'b0;
      if (state == CHECK) begin
        if (accept) begin
          omegaOut   <= data;
          omegaValid <= 1'b1;
        end else begin
          frameErr <= 1'b1;
          if (errCount != '1) errCount <= errCount + ERR_CNT_W'(1);
        end
      end
    end
  end

endmodule
